// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types and widths for the GCD engine and its arbiter
package gcd_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } gcd_state_t;

endpackage

// File: rtl/gcd_arbiter_if.sv
// rtl/gcd_arbiter_if.sv - requester and engine signals of the shared GCD arbiter
interface gcd_arbiter_if #(
  parameter int N_REQ = 2
);
  import gcd_pkg::*;

  logic [N_REQ-1:0]        REQ;
  logic [DATA_W*N_REQ-1:0] REQ_A;
  logic [DATA_W*N_REQ-1:0] REQ_B;
  logic [N_REQ-1:0]        GNT;
  logic [N_REQ-1:0]        RSP_VALID;
  logic [DATA_W-1:0]       RSP_Y;
  logic                    RSP_ERROR;
  logic                    RSP_TIMEOUT;
  logic                    BUSY;
  logic                    G_START;
  logic [DATA_W-1:0]       G_A;
  logic [DATA_W-1:0]       G_B;
  logic                    G_DONE;
  logic [DATA_W-1:0]       G_Y;
  logic                    G_ERROR;

  modport master (
    output REQ, REQ_A, REQ_B, G_DONE, G_Y, G_ERROR,
    input  GNT, RSP_VALID, RSP_Y, RSP_ERROR, RSP_TIMEOUT, BUSY, G_START, G_A, G_B
  );

  modport slave (
    input  REQ, REQ_A, REQ_B, G_DONE, G_Y, G_ERROR,
    output GNT, RSP_VALID, RSP_Y, RSP_ERROR, RSP_TIMEOUT, BUSY, G_START, G_A, G_B
  );

endinterface

// File: rtl/gcd_rr_pick.sv
// rtl/gcd_rr_pick.sv - combinational round-robin picker, search starts after last_grant
module gcd_rr_pick #(
  parameter int N_REQ = 2,
  parameter int LG_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [LG_W-1:0]  last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [LG_W-1:0]  grant_idx,
  output logic             any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = LG_W'(idx);
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// rtl/gcd_arbiter.sv - round-robin sharing of one GCD engine with timeout and one-hot responses
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 255
) (
  input logic         CLK,
  input logic         RST_N,
  gcd_arbiter_if.slave bus
);

  localparam int LG_W  = $clog2(N_REQ);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  gcd_state_t        state, state_nxt;
  logic [N_REQ-1:0]  pick_oh, owner_oh;
  logic [LG_W-1:0]   pick_idx, owner_idx, last_grant;
  logic              pick_any;
  logic [TMR_W-1:0]  timer, timer_inc;
  logic              expire;
  logic [DATA_W-1:0] g_a, g_b, rsp_y;
  logic              rsp_error, rsp_timeout;

  gcd_rr_pick #(.N_REQ(N_REQ), .LG_W(LG_W)) u_pick (
    .req        (bus.REQ),
    .last_grant (last_grant),
    .grant      (pick_oh),
    .grant_idx  (pick_idx),
    .any        (pick_any)
  );

  assign timer_inc = timer + TMR_W'(1);
  assign expire    = (timer_inc == TMR_W'(TIMEOUT));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // G_DONE is checked before expiry so a same-edge completion is a normal response
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.G_DONE || expire) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      owner_oh    <= '0;
      owner_idx   <= '0;
      last_grant  <= LG_W'(N_REQ - 1);
      timer       <= '0;
      g_a         <= '0;
      g_b         <= '0;
      rsp_y       <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          owner_oh  <= pick_oh;
          owner_idx <= pick_idx;
          g_a       <= bus.REQ_A[int'(pick_idx)*DATA_W +: DATA_W];
          g_b       <= bus.REQ_B[int'(pick_idx)*DATA_W +: DATA_W];
        end
        ISSUE: timer <= '0;
        WAIT: begin
          if (bus.G_DONE) begin
            rsp_y       <= bus.G_ERROR ? '0 : bus.G_Y;
            rsp_error   <= bus.G_ERROR;
            rsp_timeout <= 1'b0;
          end else begin
            timer <= timer_inc;
            if (expire) begin
              rsp_y       <= '0;
              rsp_error   <= 1'b1;
              rsp_timeout <= 1'b1;
            end
          end
        end
        RESP: last_grant <= owner_idx;
        default: ;
      endcase
    end
  end

  assign bus.GNT         = (state == ISSUE) ? owner_oh : '0;
  assign bus.G_START     = (state == ISSUE);
  assign bus.RSP_VALID   = (state == RESP) ? owner_oh : '0;
  assign bus.BUSY        = (state != IDLE);
  assign bus.G_A         = g_a;
  assign bus.G_B         = g_b;
  assign bus.RSP_Y       = rsp_y;
  assign bus.RSP_ERROR   = rsp_error;
  assign bus.RSP_TIMEOUT = rsp_timeout;

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb/tb_gcd_arbiter.sv - directed self-checking bench for gcd_arbiter (N_REQ=2, TIMEOUT=8)
module tb_gcd_arbiter;

  logic CLK;
  logic RST_N;
  int   n_tests;
  int   n_fail;

  gcd_arbiter_if #(.N_REQ(2)) bus ();

  gcd_arbiter #(.N_REQ(2), .TIMEOUT(8)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [1:0] o_gnt, o_rsp;
  logic [7:0] o_ga, o_gb, o_y;
  logic       o_busy, o_err, o_to;
  int         o_sw, o_rk, o_xs;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Waits for G_START, plays the engine (done in WAIT cycle 'lat', 0 = never) and records the response
  task automatic run_txn(input int lat, input logic [7:0] y, input logic err, input logic drop_req);
    o_gnt = '0; o_rsp = '0; o_ga = '0; o_gb = '0; o_y = '0;
    o_busy = 1'b0; o_err = 1'b0; o_to = 1'b0; o_sw = 0; o_rk = -1; o_xs = 0;
    while (bus.G_START !== 1'b1 && o_sw < 20) begin
      step();
      o_sw++;
    end
    if (bus.G_START !== 1'b1) return;
    o_gnt  = bus.GNT;
    o_ga   = bus.G_A;
    o_gb   = bus.G_B;
    o_busy = bus.BUSY;
    if (drop_req) bus.REQ = '0;
    for (int k = 0; k < 40; k++) begin
      bus.G_DONE  = (lat != 0 && k == lat);
      bus.G_Y     = y;
      bus.G_ERROR = err;
      step();
      bus.G_DONE = 1'b0;
      if (bus.G_START === 1'b1) o_xs++;
      if (bus.RSP_VALID !== 2'b00) begin
        o_rsp = bus.RSP_VALID;
        o_y   = bus.RSP_Y;
        o_err = bus.RSP_ERROR;
        o_to  = bus.RSP_TIMEOUT;
        o_rk  = k + 1;
        break;
      end
    end
    bus.G_ERROR = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    bus.REQ = 2'b11; bus.REQ_A = {8'd30, 8'd12}; bus.REQ_B = {8'd5, 8'd4};
    bus.G_DONE = 1'b1; bus.G_Y = 8'hAA; bus.G_ERROR = 1'b1;
    repeat (3) step();
    n_tests++; if (bus.GNT !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", bus.GNT); end
    n_tests++; if (bus.RSP_VALID !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", bus.RSP_VALID); end
    n_tests++; if (bus.RSP_Y !== 8'd0 || bus.RSP_ERROR !== 1'b0 || bus.RSP_TIMEOUT !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got y=%0d e=%b t=%b want 0 0 0", bus.RSP_Y, bus.RSP_ERROR, bus.RSP_TIMEOUT); end
    n_tests++; if (bus.BUSY !== 1'b0 || bus.G_START !== 1'b0) begin n_fail++; $display("FAIL reset_busy_start: got busy=%b start=%b want 0 0", bus.BUSY, bus.G_START); end
    n_tests++; if (bus.G_A !== 8'd0 || bus.G_B !== 8'd0) begin n_fail++; $display("FAIL reset_operands: got a=%0d b=%0d want 0 0", bus.G_A, bus.G_B); end
    bus.G_DONE = 1'b0; bus.G_ERROR = 1'b0;
    RST_N = 1'b1;
    step();
    n_tests++; if (bus.GNT !== 2'b01 || bus.G_START !== 1'b1) begin n_fail++; $display("FAIL reset_first_grant: got gnt=%b start=%b want 01 1", bus.GNT, bus.G_START); end
    run_txn(2, 8'd6, 1'b0, 1'b1);
    n_tests++; if (o_rsp !== 2'b01) begin n_fail++; $display("FAIL reset_first_rsp: got %b want 01", o_rsp); end
  endtask

  task automatic test_single_req();
    bus.REQ = '0;
    step();
    bus.REQ_A = {8'd0, 8'd48}; bus.REQ_B = {8'd0, 8'd18}; bus.REQ = 2'b01;
    run_txn(5, 8'd6, 1'b0, 1'b1);
    n_tests++; if (o_sw !== 1) begin n_fail++; $display("FAIL single_req_to_gnt: got %0d cycles want 1", o_sw); end
    n_tests++; if (o_gnt !== 2'b01 || o_busy !== 1'b1) begin n_fail++; $display("FAIL single_gnt: got gnt=%b busy=%b want 01 1", o_gnt, o_busy); end
    n_tests++; if (o_ga !== 8'd48 || o_gb !== 8'd18) begin n_fail++; $display("FAIL single_operands: got a=%0d b=%0d want 48 18", o_ga, o_gb); end
    n_tests++; if (o_xs !== 0) begin n_fail++; $display("FAIL single_start_pulse: got %0d extra start cycles want 0", o_xs); end
    n_tests++; if (o_rsp !== 2'b01 || o_y !== 8'd6 || o_err !== 1'b0 || o_to !== 1'b0) begin n_fail++; $display("FAIL single_rsp: got v=%b y=%0d e=%b t=%b want 01 6 0 0", o_rsp, o_y, o_err, o_to); end
    n_tests++; if (o_rk !== 6) begin n_fail++; $display("FAIL single_latency: got %0d want 6", o_rk); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g;
    bus.REQ = '0;
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    bus.REQ_A = {8'd20, 8'd10}; bus.REQ_B = {8'd4, 8'd2}; bus.REQ = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      run_txn(2, 8'(i + 1), 1'b0, 1'b0);
      n_tests++; if (o_gnt !== exp_g) begin n_fail++; $display("FAIL fair_gnt%0d: got %b want %b", i, o_gnt, exp_g); end
      n_tests++; if (o_rsp !== exp_g || o_y !== 8'(i + 1)) begin n_fail++; $display("FAIL fair_rsp%0d: got v=%b y=%0d want %b %0d", i, o_rsp, o_y, exp_g, i + 1); end
      n_tests++; if (o_ga !== ((i % 2 == 0) ? 8'd10 : 8'd20)) begin n_fail++; $display("FAIL fair_ga%0d: got %0d want %0d", i, o_ga, (i % 2 == 0) ? 10 : 20); end
      n_tests++; if (o_sw !== ((i == 0) ? 1 : 2)) begin n_fail++; $display("FAIL back_to_back%0d: got %0d cycles want %0d", i, o_sw, (i == 0) ? 1 : 2); end
    end
    bus.REQ = '0;
  endtask

  task automatic test_engine_error();
    step();
    bus.REQ_A = {8'd0, 8'd77}; bus.REQ_B = {8'd9, 8'd5}; bus.REQ = 2'b10;
    run_txn(3, 8'h55, 1'b1, 1'b1);
    n_tests++; if (o_gnt !== 2'b10 || o_ga !== 8'd0 || o_gb !== 8'd9) begin n_fail++; $display("FAIL err_issue: got gnt=%b a=%0d b=%0d want 10 0 9", o_gnt, o_ga, o_gb); end
    n_tests++; if (o_rsp !== 2'b10 || o_y !== 8'd0 || o_err !== 1'b1 || o_to !== 1'b0) begin n_fail++; $display("FAIL err_rsp: got v=%b y=%0d e=%b t=%b want 10 0 1 0", o_rsp, o_y, o_err, o_to); end
  endtask

  task automatic test_timeout();
    step();
    bus.REQ_A = {8'd40, 8'd7}; bus.REQ_B = {8'd24, 8'd3}; bus.REQ = 2'b01;
    run_txn(0, 8'd0, 1'b0, 1'b1);
    n_tests++; if (o_rk !== 9) begin n_fail++; $display("FAIL timeout_latency: got %0d want 9", o_rk); end
    n_tests++; if (o_rsp !== 2'b01 || o_y !== 8'd0 || o_err !== 1'b1 || o_to !== 1'b1) begin n_fail++; $display("FAIL timeout_rsp: got v=%b y=%0d e=%b t=%b want 01 0 1 1", o_rsp, o_y, o_err, o_to); end
    step();
    bus.REQ = 2'b10;
    run_txn(8, 8'd8, 1'b0, 1'b1);
    n_tests++; if (o_rk !== 9) begin n_fail++; $display("FAIL same_edge_latency: got %0d want 9", o_rk); end
    n_tests++; if (o_rsp !== 2'b10 || o_y !== 8'd8 || o_err !== 1'b0 || o_to !== 1'b0) begin n_fail++; $display("FAIL same_edge_rsp: got v=%b y=%0d e=%b t=%b want 10 8 0 0", o_rsp, o_y, o_err, o_to); end
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    int n;
    step();
    bus.REQ_A = {8'd0, 8'd12}; bus.REQ_B = {8'd0, 8'd8}; bus.REQ = 2'b01;
    n = 0;
    while (bus.G_START !== 1'b1 && n < 20) begin step(); n++; end
    n_tests++; if (bus.G_START !== 1'b1) begin n_fail++; $display("FAIL midwait_start: got %b want 1", bus.G_START); end
    bus.REQ = '0;
    step();
    step();
    n_tests++; if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL midwait_busy_before: got %b want 1", bus.BUSY); end
    RST_N = 1'b0;
    #1;
    n_tests++; if (bus.BUSY !== 1'b0 || bus.G_A !== 8'd0 || bus.RSP_VALID !== 2'b00) begin n_fail++; $display("FAIL midwait_async_reset: got busy=%b a=%0d v=%b want 0 0 00", bus.BUSY, bus.G_A, bus.RSP_VALID); end
    step();
    RST_N = 1'b1;
    bus.G_DONE = 1'b1; bus.G_Y = 8'd4;
    step();
    bus.G_DONE = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.RSP_VALID !== 2'b00 || bus.BUSY !== 1'b0) seen++;
      step();
    end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL midwait_late_done: got %0d active cycles want 0", seen); end
    bus.REQ_A = {8'd15, 8'd9}; bus.REQ_B = {8'd10, 8'd6}; bus.REQ = 2'b11;
    run_txn(2, 8'd3, 1'b0, 1'b1);
    n_tests++; if (o_sw !== 1 || o_gnt !== 2'b01 || o_ga !== 8'd9) begin n_fail++; $display("FAIL midwait_regrant: got sw=%0d gnt=%b a=%0d want 1 01 9", o_sw, o_gnt, o_ga); end
    n_tests++; if (o_rsp !== 2'b01 || o_y !== 8'd3 || o_err !== 1'b0) begin n_fail++; $display("FAIL midwait_rsp: got v=%b y=%0d e=%b want 01 3 0", o_rsp, o_y, o_err); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RST_N = 1'b0;
    bus.REQ = '0; bus.REQ_A = '0; bus.REQ_B = '0;
    bus.G_DONE = 1'b0; bus.G_Y = '0; bus.G_ERROR = 1'b0;
    test_reset();
    test_single_req();
    test_fairness();
    test_engine_error();
    test_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
